// File: rtl/vproc_wait_mem.sv
// vproc_wait_mem: word-addressed VProc bus slave with programmable wait states before each ack.
// Optional feature macro VPROC_MEM_WAIT_RAND_EN: wait count per access = LFSR[7:0] & WAIT_STATES.
module vproc_wait_mem #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [3:0]  BE,
  input  logic        WE,
  input  logic        RD,
  input  logic [31:0] DataOut,
  output logic [31:0] DataIn,
  output logic        WRAck,
  output logic        RDAck
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [7:0]  WAIT_MASK = 8'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              wait_cnt_q, wait_cnt_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic [31:0]             hold_q, hold_d;
  logic [31:0]             data_in_q, data_in_d;
  logic                    wrack_q, wrack_d;
  logic                    rdack_q, rdack_d;
  logic [7:0]              wait_val;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    accept;
  logic [31:0]             rd_word;
  logic [31:0]             mem [DEPTH];
  logic                    unused_addr_hi;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Upper address bits alias onto the same words.
  assign idx            = Addr[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^Addr[31:ADDR_WIDTH];
  assign accept         = (state_q == IDLE) && (WE || RD);
  assign rd_word        = mem[idx];

`ifdef VPROC_MEM_WAIT_RAND_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign wait_val = lfsr_q[7:0] & WAIT_MASK;

  // Fibonacci LFSR, taps 16,14,13,11; advances once per accepted access.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  logic [15:0] unused_seed;

  assign wait_val    = WAIT_MASK;
  assign unused_seed = LFSR_SEED;
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    hold_d     = hold_q;
    data_in_d  = data_in_q;
    wrack_d    = 1'b0;
    rdack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (WE || RD) begin
          wr_d       = WE;
          rd_d       = RD;
          wait_cnt_d = wait_val;
          // Pre-write word, so a combined WE+RD returns the old contents.
          hold_d     = rd_word;
          if (wait_val == 8'd0) begin
            state_d = ACK;
            wrack_d = WE;
            rdack_d = RD;
            if (RD) data_in_d = rd_word;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 8'd1;
        if (wait_cnt_q == 8'd1) begin
          state_d = ACK;
          wrack_d = wr_q;
          rdack_d = rd_q;
          if (rd_q) data_in_d = hold_q;
        end
      end
      ACK: begin
        // The master still shows the completed request on this edge; ignore it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      data_in_q  <= 32'd0;
      wrack_q    <= 1'b0;
      rdack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      data_in_q  <= data_in_d;
      wrack_q    <= wrack_d;
      rdack_q    <= rdack_d;
    end
  end

  always_ff @(posedge Clk) begin
    hold_q <= hold_d;
  end

  // Writes land on the accept edge; memory is never cleared by reset.
  always_ff @(posedge Clk) begin
    if (!Reset && accept && WE) mem[idx] <= merge_bytes(rd_word, DataOut, BE);
  end

  assign DataIn = data_in_q;
  assign WRAck  = wrack_q;
  assign RDAck  = rdack_q;

endmodule

// File: tb/tb_vproc_wait_mem.sv
// Bench for vproc_wait_mem: three instances (wait masks 0, 4 or 7, 10) against a behavioural memory/latency model.
module tb_vproc_wait_mem;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef VPROC_MEM_WAIT_RAND_EN
  localparam int W1 = 7;
`else
  localparam int W1 = 4;
`endif

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [2:0][31:0] addr, dout, din;
  logic [2:0][3:0]  be;
  logic [2:0]       we, rd, wrack, rdack;

  always #5 Clk = ~Clk;

  vproc_wait_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_w0 (
    .Clk(Clk), .Reset(Reset), .Addr(addr[0]), .BE(be[0]), .WE(we[0]), .RD(rd[0]),
    .DataOut(dout[0]), .DataIn(din[0]), .WRAck(wrack[0]), .RDAck(rdack[0]));
  vproc_wait_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(W1)) u_w1 (
    .Clk(Clk), .Reset(Reset), .Addr(addr[1]), .BE(be[1]), .WE(we[1]), .RD(rd[1]),
    .DataOut(dout[1]), .DataIn(din[1]), .WRAck(wrack[1]), .RDAck(rdack[1]));
  vproc_wait_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(10)) u_w2 (
    .Clk(Clk), .Reset(Reset), .Addr(addr[2]), .BE(be[2]), .WE(we[2]), .RD(rd[2]),
    .DataOut(dout[2]), .DataIn(din[2]), .WRAck(wrack[2]), .RDAck(rdack[2]));

  typedef struct {
    bit          we;
    bit          rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_din;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_dout [3];
  int unsigned mdl_lfsr [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int mask_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? W1 : 10;
  endfunction

  // Wait count for the next access of instance i.
  function automatic int next_wait(input int i);
`ifdef VPROC_MEM_WAIT_RAND_EN
    int unsigned s, fb;
    int w;
    s = mdl_lfsr[i];
    w = int'(s & 255) & mask_of(i);
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    mdl_lfsr[i] = ((s << 1) | fb) & 32'hFFFF;
    return w;
`else
    return mask_of(i);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mdl_dout[i] = 32'd0;
      mdl_lfsr[i] = 32'hACE1;
    end
  endtask

  task automatic mdl_apply(input int i, input bit w, input bit r, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
    int key;
    logic [31:0] old;
    key = i * DEPTH + int'(a % DEPTH);
    old = mdl_mem.exists(key) ? mdl_mem[key] : 32'd0;
    if (r) mdl_dout[i] = old;
    if (w) begin
      for (int k = 0; k < 4; k++) if (b[k]) old[8*k +: 8] = d[8*k +: 8];
      mdl_mem[key] = old;
    end
  endtask

  // One isolated access: drive after a falling edge, wait for the ack, then drop the request.
  task automatic do_access(input int i, input bit w, input bit r, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d, input string tag);
    int lat, expw;
    bit seen;
    @(negedge Clk);
    we[i] = w; rd[i] = r; addr[i] = a; be[i] = b; dout[i] = d;
    expw = next_wait(i);
    mdl_apply(i, w, r, a, b, d);
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 300) begin
      @(negedge Clk);
      lat++;
      if (wrack[i] || rdack[i]) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, lat, expw + 1);
      check({tag, "_wrack"}, 32'(wrack[i]), 32'(w));
      check({tag, "_rdack"}, 32'(rdack[i]), 32'(r));
      check({tag, "_datain"}, din[i], mdl_dout[i]);
    end
    we[i] = 1'b0; rd[i] = 1'b0;
    @(negedge Clk);
    check({tag, "_ack_single"}, {30'd0, wrack[i], rdack[i]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int   expw, cyc, k;
    bit   seen;
    logic [31:0] a, d;
    logic [3:0]  b;

    tbl[0]  = '{1, 0, 32'd3,          4'hF, 32'hDEADBEEF, 32'h00000000};
    tbl[1]  = '{0, 1, 32'd3,          4'h0, 32'h00000000, 32'hDEADBEEF};
    tbl[2]  = '{1, 0, 32'd5,          4'hF, 32'hFFFFFFFF, 32'hDEADBEEF};
    tbl[3]  = '{1, 0, 32'd5,          4'h5, 32'h11223344, 32'hDEADBEEF};
    tbl[4]  = '{0, 1, 32'd5,          4'h0, 32'h00000000, 32'hFF22FF44};
    tbl[5]  = '{1, 1, 32'd5,          4'h3, 32'hA5A5A5A5, 32'hFF22FF44};
    tbl[6]  = '{0, 1, 32'd5,          4'h0, 32'h00000000, 32'hFF22A5A5};
    tbl[7]  = '{1, 0, 32'd1026,       4'hF, 32'h0BADF00D, 32'hFF22A5A5};
    tbl[8]  = '{0, 1, 32'd2,          4'h0, 32'h00000000, 32'h0BADF00D};
    tbl[9]  = '{1, 0, 32'd1023,       4'hF, 32'hCAFEBABE, 32'h0BADF00D};
    tbl[10] = '{0, 1, 32'hFFFFFFFF,   4'h0, 32'h00000000, 32'hCAFEBABE};

    we = '0; rd = '0; addr = '0; be = '0; dout = '0;
    model_reset();

    // Reset, then five idle cycles with quiet outputs.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("reset_acks_i%0d_c%0d", i, c), {30'd0, wrack[i], rdack[i]}, 32'd0);
        check($sformatf("reset_datain_i%0d_c%0d", i, c), din[i], 32'd0);
      end
    end

    // Directed vectors on the zero-wait instance.
    for (int v = 0; v < 11; v++) begin
      do_access(0, tbl[v].we, tbl[v].rd, tbl[v].addr, tbl[v].be, tbl[v].wdata, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_table_datain", v), din[0], tbl[v].exp_din);
    end

    // Randomized traffic on the waited instance: fill 16 words, then mixed reads/writes.
    for (int n = 0; n < 16; n++) begin
      a = 32'(n) + (32'($urandom_range(0, 3)) << AW);
      do_access(1, 1'b1, 1'b0, a, 4'hF, $urandom, $sformatf("fill%0d", n));
    end
    for (int n = 0; n < 48; n++) begin
      a = 32'($urandom_range(0, 15)) + (32'($urandom_range(0, 7)) << AW);
      b = 4'($urandom_range(1, 15));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_access(1, 1'b1, 1'b0, a, b, d, $sformatf("rnd%0d_wr", n));
      else                           do_access(1, 1'b0, 1'b1, a, 4'h0, d, $sformatf("rnd%0d_rd", n));
    end

    // Back-to-back reads: request re-presented on the same edge each ack completes.
    @(negedge Clk);
    k = 0;
    rd[1] = 1'b1; addr[1] = 32'd0; be[1] = 4'h0;
    expw = next_wait(1);
    mdl_apply(1, 1'b0, 1'b1, 32'd0, 4'h0, 32'd0);
    while (k < 8) begin
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 300) begin
        @(negedge Clk);
        cyc++;
        if (rdack[1] || wrack[1]) seen = 1'b1;
      end
      check($sformatf("b2b%0d_ack_seen", k), 32'(seen), 32'd1);
      check($sformatf("b2b%0d_interval", k), cyc, (k == 0) ? expw + 1 : expw + 2);
      check($sformatf("b2b%0d_rdack_only", k), {30'd0, wrack[1], rdack[1]}, 32'd1);
      check($sformatf("b2b%0d_datain", k), din[1], mdl_dout[1]);
      k++;
      if (!seen) k = 8;
      if (k < 8) begin
        addr[1] = 32'(k);
        expw = next_wait(1);
        mdl_apply(1, 1'b0, 1'b1, 32'(k), 4'h0, 32'd0);
      end else begin
        rd[1] = 1'b0;
      end
    end
    @(negedge Clk);
    check("b2b_ack_single", {30'd0, wrack[1], rdack[1]}, 32'd0);

    // Reset in the middle of a long wait: write stays, no ack, outputs cleared.
    do_access(2, 1'b1, 1'b0, 32'd4, 4'hF, 32'h12345678, "w10_wr");
    do_access(2, 1'b0, 1'b1, 32'd4, 4'h0, 32'd0, "w10_rd");
    @(negedge Clk);
    we[2] = 1'b1; addr[2] = 32'd9; be[2] = 4'hF; dout[2] = 32'h55AA33CC;
    expw = next_wait(2);
    mdl_apply(2, 1'b1, 1'b0, 32'd9, 4'hF, 32'h55AA33CC);
    if (expw >= 4) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge Clk);
        check($sformatf("midrst_pre_ack_c%0d", c), {30'd0, wrack[2], rdack[2]}, 32'd0);
      end
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      we[2] = 1'b0;
      model_reset();
      for (int c = 0; c < 14; c++) begin
        @(negedge Clk);
        check($sformatf("midrst_no_ack_c%0d", c), {30'd0, wrack[2], rdack[2]}, 32'd0);
        check($sformatf("midrst_datain_c%0d", c), din[2], 32'd0);
      end
      check("midrst_other_datain", din[0], 32'd0);
    end else begin
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 300) begin
        @(negedge Clk);
        cyc++;
        if (wrack[2]) seen = 1'b1;
      end
      check("midrst_short_latency", cyc, expw + 1);
      we[2] = 1'b0;
      @(negedge Clk);
    end
    do_access(2, 1'b0, 1'b1, 32'd9, 4'h0, 32'd0, "midrst_readback");
    check("midrst_readback_value", din[2], 32'h55AA33CC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
